// File: rtl/moore_pkg.sv
// Shared constants and the elaboration-time prefix-fallback function for the
// serial pattern detector.
package moore_pkg;

    localparam int                     MAX_SEQ_LEN = 16;
    localparam int                     DEF_SEQ_LEN = 4;
    localparam logic [DEF_SEQ_LEN-1:0] DEF_SEQ     = 4'b1101;

    // Longest prefix of the pattern that is a suffix of (k matched bits, then b).
    // The pattern occupies seq[len-1:0], MSB received first. Evaluated only on
    // constants, so it folds into a lookup table at elaboration.
    function automatic int kmp_next(
        input logic [MAX_SEQ_LEN-1:0] seq,
        input int                     len,
        input int                     k,
        input logic                   b
    );
        int   best;
        int   lmax;
        int   si;
        logic ok;
        logic sb;
        best = 0;
        lmax = (k + 1 < len) ? k + 1 : len;
        for (int l = 1; l <= lmax; l++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                si = k + 1 - l + j;
                sb = (si < k) ? seq[4'(len - 1 - si)] : b;
                if (sb != seq[4'(len - 1 - j)]) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
            if (ok) begin
                best = l;
            end else begin
                best = best;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/moore_1101_detector.sv
// Moore FSM detecting a parameterised serial bit pattern; state is the number of
// pattern bits matched so far, with a saturating match counter alongside.
module moore_1101_detector
    import moore_pkg::*;
#(
    parameter int                 SEQ_LEN = DEF_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ,
    parameter int                 OVERLAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data,
    output logic        detected,
    output logic [15:0] match_count
);

    localparam int                     SW       = $clog2(SEQ_LEN + 1);
    localparam int                     NTBL     = 2 ** (SW + 1);
    localparam logic [SW-1:0]          MATCH_ST = SW'(SEQ_LEN);
    localparam logic [MAX_SEQ_LEN-1:0] SEQ_EXT  = 16'(SEQ);

    logic [SW-1:0] state;
    logic [SW-1:0] next_state_s;
    logic [SW-1:0] next_tbl [NTBL];

    // Transition table indexed by {state, data}; unused encodings fall back to 0.
    // In non-overlapping mode the match state behaves like the empty state.
    for (genvar i = 0; i < NTBL; i++) begin : g_tbl
        localparam int   K = i / 2;
        localparam logic B = 1'(i % 2);
        if (K > SEQ_LEN) begin : g_unused
            assign next_tbl[i] = {SW{1'b0}};
        end else if ((K == SEQ_LEN) && (OVERLAP == 0)) begin : g_restart
            assign next_tbl[i] = SW'(kmp_next(SEQ_EXT, SEQ_LEN, 0, B));
        end else begin : g_kmp
            assign next_tbl[i] = SW'(kmp_next(SEQ_EXT, SEQ_LEN, K, B));
        end
    end

    // State register and saturating match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= {SW{1'b0}};
            match_count <= 16'h0000;
        end else begin
            state <= next_state_s;
            if ((next_state_s == MATCH_ST) && (match_count != 16'hFFFF)) begin
                match_count <= match_count + 16'h0001;
            end else begin
                match_count <= match_count;
            end
        end
    end

    // Next-state lookup.
    always_comb begin
        next_state_s = {SW{1'b0}};
        if (state <= MATCH_ST) begin
            next_state_s = next_tbl[{state, data}];
        end else begin
            next_state_s = {SW{1'b0}};
        end
    end

    // Moore output decode.
    always_comb begin
        detected = 1'b0;
        if (state == MATCH_ST) begin
            detected = 1'b1;
        end else begin
            detected = 1'b0;
        end
    end

endmodule

// File: tb/tb_moore_1101_detector.sv
// Directed bench: one non-overlapping and one overlapping detector fed the same
// serial stream, checked against hand-derived state traces.
module tb_moore_1101_detector;

    logic        clk;
    logic        rst;
    logic        data;
    logic        det0;
    logic        det1;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int tests = 0;
    int fails = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    moore_1101_detector #(.OVERLAP(0)) dut (
        .clk(clk), .rst(rst), .data(data), .detected(det0), .match_count(cnt0)
    );

    moore_1101_detector #(.OVERLAP(1)) dut_ov (
        .clk(clk), .rst(rst), .data(data), .detected(det1), .match_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int s0, input int s1);
        check({tag, " state"},     32'(dut.state),    32'(s0));
        check({tag, " det"},       32'(det0),         (s0 == 4) ? 32'd1 : 32'd0);
        check({tag, " cnt"},       32'(cnt0),         32'(exp_cnt0));
        check({tag, " ov_state"},  32'(dut_ov.state), 32'(s1));
        check({tag, " ov_det"},    32'(det1),         (s1 == 4) ? 32'd1 : 32'd0);
        check({tag, " ov_cnt"},    32'(cnt1),         32'(exp_cnt1));
    endtask

    // Asserts rst between clock edges, checks the asynchronous clear, releases on a negedge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst  = 1'b1;
        data = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        #1;
        check_all({tag, " rst"}, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bits and expected states are given as digit strings, one character per cycle.
    task automatic run_seg(input string tag, input string bits, input string st0, input string st1);
        int s0;
        int s1;
        for (int i = 0; i < bits.len(); i++) begin
            @(negedge clk);
            data = (bits[i] == 8'h31) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            s0 = int'(st0[i]) - 48;
            s1 = int'(st1[i]) - 48;
            if (s0 == 4) exp_cnt0++;
            if (s1 == 4) exp_cnt1++;
            check_all($sformatf("%s[%0d]", tag, i + 1), s0, s1);
        end
    endtask

    initial begin
        rst  = 1'b1;
        data = 1'b0;
        #6;
        check_all("por", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single match, then detected drops after one cycle.
        run_seg("basic", "11010", "12340", "12340");

        // 1101101: overlap mode reuses the trailing 1.
        pulse_reset("r1");
        run_seg("ovl", "1101101", "1234101", "1234234");

        // Long stream with runs of 1s holding at state 2.
        pulse_reset("r2");
        run_seg("long", "110110110110111011101",
                "123410123410122341234",
                "123423423423422342234");
        check("long final cnt", 32'(cnt0), 32'd4);
        check("long final ov_cnt", 32'(cnt1), 32'd6);

        // Reset mid-sequence discards 110; first edge after release samples a 1.
        pulse_reset("r3");
        run_seg("part", "110", "123", "123");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("midrst", 0, 0);
        @(negedge clk);
        data = 1'b1;
        rst  = 1'b0;
        @(posedge clk);
        #1;
        check_all("after_rel", 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
